// File: rtl/mux_n_to_1_pipe.sv
// N-way data-select mux with a registered output stage, stall/flush control,
// a sticky out-of-range select flag and a saturating forward-event counter.
module mux_n_to_1_pipe #(
  parameter int unsigned SIZE  = 32,
  parameter int unsigned NUM   = 3,
  parameter int unsigned SEL_W = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NUM*SIZE-1:0] data_i,
  input  logic [SEL_W-1:0]    select_i,
  input  logic                valid_i,
  input  logic                stall_i,
  input  logic                flush_i,
  input  logic                clr_i,
  output logic [SIZE-1:0]     data_o,
  output logic                valid_o,
  output logic                err_o,
  output logic [SEL_W-1:0]    err_sel_o,
  output logic [CNT_W-1:0]    fwd_cnt_o
);

  // Reject configurations where the select cannot address every input.
  if (NUM < 2 || (1 << SEL_W) < NUM) begin : g_bad_cfg
    $error("mux_n_to_1_pipe: NUM must be >= 2 and 2**SEL_W must be >= NUM");
  end

  logic [SIZE-1:0]  data_q, data_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [SEL_W-1:0] err_sel_q, err_sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0]      sel_idx;
  logic             sel_legal;
  logic [SIZE-1:0]  sel_data;

  assign sel_idx   = 32'(select_i);
  assign sel_legal = (sel_idx < NUM);

  // Pick the addressed input; out-of-range selects yield zero but are never loaded.
  always_comb begin
    sel_data = '0;
    for (int unsigned k = 0; k < NUM; k++) begin
      if (sel_idx == k) sel_data = data_i[k*SIZE +: SIZE];
    end
  end

  // Next state: flush beats stall beats load; clear beats counter/error updates.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    err_d     = err_q;
    err_sel_d = err_sel_q;
    cnt_d     = cnt_q;
    if (flush_i) begin
      data_d  = '0;
      valid_d = 1'b0;
    end else if (!stall_i) begin
      // Illegal selects keep the previous data rather than loading garbage.
      if (sel_legal) data_d = sel_data;
      valid_d = valid_i & sel_legal;
      if (valid_i && !sel_legal && !err_q) begin
        err_d     = 1'b1;
        err_sel_d = select_i;
      end
      if (valid_i && sel_legal && (select_i != '0) && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    if (clr_i) begin
      err_d     = 1'b0;
      err_sel_d = '0;
      cnt_d     = '0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      err_sel_q <= '0;
      cnt_q     <= '0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      err_sel_q <= err_sel_d;
      cnt_q     <= cnt_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign err_o     = err_q;
  assign err_sel_o = err_sel_q;
  assign fwd_cnt_o = cnt_q;

endmodule

// File: tb/tb_mux_n_to_1_pipe.sv
// Bench for mux_n_to_1_pipe: a narrow-counter 3-input instance and a wide 8-input
// instance, both compared every cycle against a rule-level reference model.
module tb_mux_n_to_1_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: SIZE=32, NUM=3, SEL_W=2, CNT_W=4
  logic [95:0] a_data;
  logic [1:0]  a_sel;
  logic        a_valid, a_stall, a_flush, a_clr;
  logic [31:0] a_q;
  logic        a_vo, a_err;
  logic [1:0]  a_esel;
  logic [3:0]  a_cnt;

  // Instance B: SIZE=8, NUM=8, SEL_W=3, CNT_W=16
  logic [63:0] b_data;
  logic [2:0]  b_sel;
  logic        b_valid, b_stall, b_flush, b_clr;
  logic [7:0]  b_q;
  logic        b_vo, b_err;
  logic [2:0]  b_esel;
  logic [15:0] b_cnt;

  mux_n_to_1_pipe #(.SIZE(32), .NUM(3), .SEL_W(2), .CNT_W(4)) u_dut_a (
    .clk_i(clk), .rst_i(rst_n), .data_i(a_data), .select_i(a_sel), .valid_i(a_valid),
    .stall_i(a_stall), .flush_i(a_flush), .clr_i(a_clr), .data_o(a_q), .valid_o(a_vo),
    .err_o(a_err), .err_sel_o(a_esel), .fwd_cnt_o(a_cnt)
  );

  mux_n_to_1_pipe #(.SIZE(8), .NUM(8), .SEL_W(3), .CNT_W(16)) u_dut_b (
    .clk_i(clk), .rst_i(rst_n), .data_i(b_data), .select_i(b_sel), .valid_i(b_valid),
    .stall_i(b_stall), .flush_i(b_flush), .clr_i(b_clr), .data_o(b_q), .valid_o(b_vo),
    .err_o(b_err), .err_sel_o(b_esel), .fwd_cnt_o(b_cnt)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] data;
    logic        valid;
    logic        err;
    int          esel;
    int          cnt;
  } mst_t;

  mst_t ma, mb;

  // Reference behaviour of one clock edge, written from the select/priority rules.
  function automatic mst_t model(mst_t s, int num, int size, int cmax, logic flush,
                                 logic stall, logic vin, logic clr, int sel,
                                 logic [255:0] d);
    mst_t n = s;
    logic [255:0] sh;
    if (flush) begin
      n.data  = 0;
      n.valid = 1'b0;
    end else if (!stall) begin
      if (sel < num) begin
        sh     = d >> (sel * size);
        n.data = sh[31:0] & 32'((64'd1 << size) - 64'd1);
      end
      n.valid = vin && (sel < num);
      if (vin && sel >= num && !s.err) begin
        n.err  = 1'b1;
        n.esel = sel;
      end
      if (vin && sel < num && sel != 0 && s.cnt < cmax) n.cnt = s.cnt + 1;
    end
    if (clr) begin
      n.err  = 1'b0;
      n.esel = 0;
      n.cnt  = 0;
    end
    return n;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("a_data",    a_q,             ma.data);
    check("a_valid",   32'(a_vo),       32'(ma.valid));
    check("a_err",     32'(a_err),      32'(ma.err));
    check("a_err_sel", 32'(a_esel),     32'(ma.esel));
    check("a_cnt",     32'(a_cnt),      32'(ma.cnt));
    check("b_data",    32'(b_q),        mb.data);
    check("b_valid",   32'(b_vo),       32'(mb.valid));
    check("b_err",     32'(b_err),      32'(mb.err));
    check("b_err_sel", 32'(b_esel),     32'(mb.esel));
    check("b_cnt",     32'(b_cnt),      32'(mb.cnt));
  endtask

  task automatic reset_models();
    ma = '{0, 1'b0, 1'b0, 0, 0};
    mb = '{0, 1'b0, 1'b0, 0, 0};
  endtask

  // One rising edge: advance both models from the pre-edge inputs, then sample.
  task automatic tick();
    @(posedge clk);
    ma = model(ma, 3, 32, 15, a_flush, a_stall, a_valid, a_clr, int'(a_sel), 256'(a_data));
    mb = model(mb, 8, 8, 65535, b_flush, b_stall, b_valid, b_clr, int'(b_sel), 256'(b_data));
    #1;
    check_all();
  endtask

  task automatic drive_a(int sel, logic vin, logic stall, logic flush, logic clr);
    a_sel   = 2'(sel);
    a_valid = vin;
    a_stall = stall;
    a_flush = flush;
    a_clr   = clr;
  endtask

  task automatic drive_b(int sel, logic vin, logic stall, logic flush, logic clr);
    b_sel   = 3'(sel);
    b_valid = vin;
    b_stall = stall;
    b_flush = flush;
    b_clr   = clr;
  endtask

  initial begin
    rst_n  = 1'b0;
    a_data = '0;
    b_data = '0;
    drive_a(0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0);
    reset_models();
    #2;
    check_all();
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Basic select
    a_data = {32'h33333333, 32'h22222222, 32'h11111111};
    drive_a(0, 1, 0, 0, 0); tick();
    check("basic_sel0", a_q, 32'h11111111);
    drive_a(1, 1, 0, 0, 0); tick();
    check("basic_sel1", a_q, 32'h22222222);
    drive_a(2, 1, 0, 0, 0); tick();
    check("basic_sel2", a_q, 32'h33333333);
    check("basic_cnt", 32'(a_cnt), 32'd2);

    // Illegal select after a load of 0x22222222
    drive_a(1, 1, 0, 0, 0); tick();
    drive_a(3, 1, 0, 0, 0); tick();
    check("illegal_data", a_q, 32'h22222222);
    check("illegal_valid", 32'(a_vo), 32'd0);
    check("illegal_err", 32'(a_err), 32'd1);
    check("illegal_esel", 32'(a_esel), 32'd3);
    drive_a(3, 1, 0, 0, 0); tick();
    check("illegal_esel_sticky", 32'(a_esel), 32'd3);
    drive_a(0, 0, 0, 0, 1); tick();
    check("clr_err", 32'(a_err), 32'd0);

    // Stall then flush+stall
    drive_a(2, 1, 0, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      drive_a(i, 1, 1, 0, 0); tick();
      check("stall_data", a_q, 32'h33333333);
      check("stall_valid", 32'(a_vo), 32'd1);
    end
    drive_a(1, 1, 1, 1, 0); tick();
    check("flush_valid", 32'(a_vo), 32'd0);
    check("flush_data", a_q, 32'd0);

    // Saturation of the 4-bit counter
    for (int i = 0; i < 20; i++) begin
      drive_a(1, 1, 0, 0, 0); tick();
    end
    check("sat_cnt", 32'(a_cnt), 32'd15);
    drive_a(1, 1, 0, 0, 1); tick();
    check("clr_beats_inc", 32'(a_cnt), 32'd0);
    drive_a(0, 0, 0, 0, 0);

    // Wide configuration: every select legal
    for (int k = 0; k < 8; k++) b_data[k*8 +: 8] = 8'(8'h10 + k);
    for (int k = 0; k < 8; k++) begin
      drive_b(k, 1, 0, 0, 0); tick();
      check("wide_data", 32'(b_q), 32'(8'h10 + k));
      check("wide_err", 32'(b_err), 32'd0);
    end

    // Randomized traffic on both instances
    for (int i = 0; i < 400; i++) begin
      a_data = {$urandom, $urandom, $urandom};
      b_data = {$urandom, $urandom};
      drive_a(int'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
              $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 15) == 0);
      drive_b(int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
              $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 15) == 0);
      tick();
    end

    // Mid-stream reset takes effect between edges
    a_data = {32'h33333333, 32'h22222222, 32'h11111111};
    drive_a(2, 1, 0, 0, 0);
    drive_b(5, 1, 0, 0, 0);
    tick();
    tick();
    rst_n = 1'b0;
    reset_models();
    #2;
    check("rst_async_data", a_q, 32'd0);
    check_all();
    #2;
    rst_n = 1'b1;
    drive_a(1, 1, 0, 0, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
